// File: rtl/rib_arbiter_pkg.sv
// RIB bus shared definitions: bus widths, arbiter FSM states and master indices.
package rib_arbiter_pkg;

    localparam int unsigned RIB_ADDR_W = 32;
    localparam int unsigned RIB_DATA_W = 32;

    // Index wide enough for the largest supported master count (4).
    localparam int unsigned ARB_IDX_W = 2;
    typedef logic [ARB_IDX_W-1:0] arb_idx_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam arb_idx_t ARB_M_EX   = 2'd0;
    localparam arb_idx_t ARB_M_PC   = 2'd1;
    localparam arb_idx_t ARB_M_JTAG = 2'd2;
    localparam arb_idx_t ARB_M_UART = 2'd3;

endpackage

// File: rtl/rib_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, scanning cyclically.
module rib_rr_pick
    import rib_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  arb_idx_t               ptr,
    output logic                   valid,
    output arb_idx_t               idx
);

    logic [3:0] req4;
    arb_idx_t   cand;

    assign req4 = 4'(req);

    // Cyclic scan starting at ptr; the first set bit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand = arb_idx_t'((32'(ptr) + i) % NUM_MASTERS);
            if (!valid && req4[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rib_arbiter.sv
// Round-robin arbiter sharing the RIB slave port among up to four masters
// (core ex, core pc, jtag, uart debug). Latches the granted request, runs it
// to completion and produces per-master hold flags for the pipeline.
// Optional slave-ack timeout: define RIB_ARB_TIMEOUT_EN.
module rib_arbiter
    import rib_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS-1:0]    m_req_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS*32-1:0] m_addr_i,
    input  logic [NUM_MASTERS*32-1:0] m_wdata_i,
    output logic [31:0]               m_rdata_o,
    output logic [NUM_MASTERS-1:0]    m_rsp_o,
    output logic                      m_err_o,
    output logic [NUM_MASTERS-1:0]    hold_o,
    output logic                      s_req_o,
    output logic                      s_we_o,
    output logic [31:0]               s_addr_o,
    output logic [31:0]               s_wdata_o,
    input  logic [31:0]               s_rdata_i,
    input  logic                      s_ack_i
);

    arb_state_t      state, next_state;
    arb_idx_t        rr_ptr, owner;
    logic            lat_we;
    logic [31:0]     lat_addr, lat_wdata;

    logic            pick_valid;
    arb_idx_t        pick_idx;
    logic            busy, grant, done, tmo_hit;
    logic            sel_we;
    logic [31:0]     sel_addr, sel_wdata;

    rib_rr_pick #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_pick (
        .req   (m_req_i),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign busy  = (state == ARB_BUSY);
    assign grant = (state == ARB_IDLE) && pick_valid;
    assign done  = busy && (s_ack_i || tmo_hit);

`ifdef RIB_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    assign tmo_hit = busy && (tmo_cnt == 8'(TIMEOUT_CYCLES));

    // Timeout counter: cleared at grant, counts BUSY cycles without ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (grant) begin
            tmo_cnt <= '0;
        end else if (busy && !s_ack_i) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`else
    logic [7:0] unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = 8'(TIMEOUT_CYCLES);
`endif

    // Select the winning master's payload for latching at grant.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (pick_idx == arb_idx_t'(i)) begin
                sel_we    = m_we_i[i];
                sel_addr  = m_addr_i[32*i +: 32];
                sel_wdata = m_wdata_i[32*i +: 32];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: grant moves to BUSY, ack or timeout returns to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE: if (pick_valid) next_state = ARB_BUSY;
            ARB_BUSY: if (s_ack_i || tmo_hit) next_state = ARB_IDLE;
            default:  next_state = ARB_IDLE;
        endcase
    end

    // Latch owner and payload at grant and advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= '0;
            owner     <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant) begin
            owner     <= pick_idx;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            rr_ptr    <= (pick_idx == arb_idx_t'(NUM_MASTERS - 1)) ? '0 : pick_idx + 2'd1;
        end
    end

    assign s_req_o   = busy;
    assign s_we_o    = lat_we;
    assign s_addr_o  = lat_addr;
    assign s_wdata_o = lat_wdata;

    // Completion outputs: rsp pulse to the owner, data only on a real ack.
    always_comb begin
        m_rsp_o = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            m_rsp_o[i] = done && (owner == arb_idx_t'(i));
        end
        m_rdata_o = (busy && s_ack_i) ? s_rdata_i : '0;
        m_err_o   = tmo_hit && !s_ack_i;
    end

    assign hold_o = m_req_i & ~m_rsp_o;

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed self-checking bench for rib_arbiter.
module tb_rib_arbiter;

    localparam int unsigned NM = 4;

    logic            clk;
    logic            rst;
    logic [NM-1:0]   m_req_i;
    logic [NM-1:0]   m_we_i;
    logic [NM*32-1:0] m_addr_i;
    logic [NM*32-1:0] m_wdata_i;
    logic [31:0]     m_rdata_o;
    logic [NM-1:0]   m_rsp_o;
    logic            m_err_o;
    logic [NM-1:0]   hold_o;
    logic            s_req_o;
    logic            s_we_o;
    logic [31:0]     s_addr_o;
    logic [31:0]     s_wdata_o;
    logic [31:0]     s_rdata_i;
    logic            s_ack_i;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    rib_arbiter #(
        .NUM_MASTERS(NM),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_req_i   (m_req_i),
        .m_we_i    (m_we_i),
        .m_addr_i  (m_addr_i),
        .m_wdata_i (m_wdata_i),
        .m_rdata_o (m_rdata_o),
        .m_rsp_o   (m_rsp_o),
        .m_err_o   (m_err_o),
        .hold_o    (hold_o),
        .s_req_o   (s_req_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_wdata_o (s_wdata_o),
        .s_rdata_i (s_rdata_i),
        .s_ack_i   (s_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs are then driven 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        m_req_i   = '0;
        m_we_i    = '0;
        m_addr_i  = '0;
        m_wdata_i = '0;
        s_rdata_i = '0;
        s_ack_i   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        #1;
        vectors++; if (s_req_o !== 1'b0) begin errors++; $display("FAIL rst_s_req got %b exp 0", s_req_o); end
        vectors++; if (s_we_o !== 1'b0) begin errors++; $display("FAIL rst_s_we got %b exp 0", s_we_o); end
        vectors++; if (s_addr_o !== 32'h0) begin errors++; $display("FAIL rst_s_addr got %h exp 0", s_addr_o); end
        vectors++; if (s_wdata_o !== 32'h0) begin errors++; $display("FAIL rst_s_wdata got %h exp 0", s_wdata_o); end
        vectors++; if (m_rsp_o !== 4'b0000) begin errors++; $display("FAIL rst_rsp got %b exp 0000", m_rsp_o); end
        vectors++; if (m_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", m_rdata_o); end
        vectors++; if (m_err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", m_err_o); end
        vectors++; if (hold_o !== 4'b0000) begin errors++; $display("FAIL rst_hold got %b exp 0000", hold_o); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        do_reset();
        m_req_i = 4'b0001;
        m_addr_i[31:0] = 32'h1000_0004;
        #1;
        vectors++; if (hold_o !== 4'b0001) begin errors++; $display("FAIL single_hold_req got %b exp 0001", hold_o); end
        vectors++; if (s_req_o !== 1'b0) begin errors++; $display("FAIL single_sreq_idle got %b exp 0", s_req_o); end
        step(); #1;
        vectors++; if (s_req_o !== 1'b1) begin errors++; $display("FAIL single_sreq got %b exp 1", s_req_o); end
        vectors++; if (s_addr_o !== 32'h1000_0004) begin errors++; $display("FAIL single_addr got %h exp 10000004", s_addr_o); end
        vectors++; if (s_we_o !== 1'b0) begin errors++; $display("FAIL single_we got %b exp 0", s_we_o); end
        vectors++; if (m_rsp_o !== 4'b0000) begin errors++; $display("FAIL single_rsp_early got %b exp 0000", m_rsp_o); end
        step(); #1;
        vectors++; if (m_rsp_o !== 4'b0000) begin errors++; $display("FAIL single_rsp_wait got %b exp 0000", m_rsp_o); end
        step();
        s_ack_i   = 1'b1;
        s_rdata_i = 32'hA5A5_0001;
        #1;
        vectors++; if (m_rsp_o !== 4'b0001) begin errors++; $display("FAIL single_rsp got %b exp 0001", m_rsp_o); end
        vectors++; if (m_rdata_o !== 32'hA5A5_0001) begin errors++; $display("FAIL single_rdata got %h exp a5a50001", m_rdata_o); end
        vectors++; if (m_err_o !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", m_err_o); end
        vectors++; if (hold_o[0] !== 1'b0) begin errors++; $display("FAIL single_hold_ack got %b exp 0", hold_o[0]); end
        step();
        clear_inputs();
        #1;
        vectors++; if (s_req_o !== 1'b0) begin errors++; $display("FAIL single_sreq_drop got %b exp 0", s_req_o); end
        vectors++; if (m_rdata_o !== 32'h0) begin errors++; $display("FAIL single_rdata_idle got %h exp 0", m_rdata_o); end
    endtask

    task automatic test_round_robin();
        int unsigned exp_order [5] = '{0, 1, 2, 3, 0};
        logic [3:0]  exp_rsp;
        logic [31:0] exp_addr;
        do_reset();
        for (int i = 0; i < 4; i++) m_addr_i[32*i +: 32] = 32'h3000_0000 + 32'(i) * 32'h10;
        m_req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            s_ack_i   = 1'b1;
            s_rdata_i = 32'hC0DE_0000 + 32'(k);
            exp_rsp   = 4'b0001 << exp_order[k];
            exp_addr  = 32'h3000_0000 + exp_order[k] * 32'h10;
            #1;
            vectors++; if (s_req_o !== 1'b1) begin errors++; $display("FAIL rr_sreq[%0d] got %b exp 1", k, s_req_o); end
            vectors++; if (s_addr_o !== exp_addr) begin errors++; $display("FAIL rr_addr[%0d] got %h exp %h", k, s_addr_o, exp_addr); end
            vectors++; if (m_rsp_o !== exp_rsp) begin errors++; $display("FAIL rr_rsp[%0d] got %b exp %b", k, m_rsp_o, exp_rsp); end
            vectors++; if (m_rdata_o !== 32'hC0DE_0000 + 32'(k)) begin errors++; $display("FAIL rr_rdata[%0d] got %h exp %h", k, m_rdata_o, 32'hC0DE_0000 + 32'(k)); end
            vectors++; if (hold_o !== (4'b1111 & ~exp_rsp)) begin errors++; $display("FAIL rr_hold[%0d] got %b exp %b", k, hold_o, 4'b1111 & ~exp_rsp); end
            step();
            s_ack_i = 1'b0;
            #1;
            vectors++; if (s_req_o !== 1'b0) begin errors++; $display("FAIL rr_gap[%0d] got %b exp 0", k, s_req_o); end
        end
        clear_inputs();
        step();
    endtask

    task automatic test_drop_req();
        do_reset();
        m_req_i = 4'b0100;
        m_we_i  = 4'b0100;
        m_addr_i[95:64]  = 32'h2000_0000;
        m_wdata_i[95:64] = 32'hDEAD_BEEF;
        step();
        m_req_i = 4'b0000;
        m_we_i  = 4'b0000;
        m_addr_i  = '0;
        m_wdata_i = '0;
        #1;
        vectors++; if (s_req_o !== 1'b1) begin errors++; $display("FAIL drop_sreq got %b exp 1", s_req_o); end
        step(); #1;
        vectors++; if (s_we_o !== 1'b1) begin errors++; $display("FAIL drop_we got %b exp 1", s_we_o); end
        vectors++; if (s_addr_o !== 32'h2000_0000) begin errors++; $display("FAIL drop_addr got %h exp 20000000", s_addr_o); end
        vectors++; if (s_wdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL drop_wdata got %h exp deadbeef", s_wdata_o); end
        s_ack_i = 1'b1;
        #1;
        vectors++; if (m_rsp_o !== 4'b0100) begin errors++; $display("FAIL drop_rsp got %b exp 0100", m_rsp_o); end
        vectors++; if (hold_o !== 4'b0000) begin errors++; $display("FAIL drop_hold got %b exp 0000", hold_o); end
        step();
        s_ack_i = 1'b0;
        #1;
        vectors++; if (s_req_o !== 1'b0) begin errors++; $display("FAIL drop_sreq_end got %b exp 0", s_req_o); end
    endtask

    task automatic test_reset_busy();
        do_reset();
        m_req_i = 4'b0010;
        m_addr_i[63:32] = 32'h4000_0010;
        m_addr_i[31:0]  = 32'h4000_0000;
        step(); #1;
        vectors++; if (s_req_o !== 1'b1) begin errors++; $display("FAIL rbusy_sreq got %b exp 1", s_req_o); end
        rst = 1'b0;
        #1;
        vectors++; if (s_req_o !== 1'b0) begin errors++; $display("FAIL rbusy_async got %b exp 0", s_req_o); end
        s_ack_i = 1'b1;
        #1;
        vectors++; if (m_rsp_o !== 4'b0000) begin errors++; $display("FAIL rbusy_rsp got %b exp 0000", m_rsp_o); end
        step();
        s_ack_i = 1'b0;
        m_req_i = 4'b0011;
        rst = 1'b1;
        step();
        s_ack_i = 1'b1;
        #1;
        vectors++; if (s_addr_o !== 32'h4000_0000) begin errors++; $display("FAIL rbusy_first_addr got %h exp 40000000", s_addr_o); end
        vectors++; if (m_rsp_o !== 4'b0001) begin errors++; $display("FAIL rbusy_first_rsp got %b exp 0001", m_rsp_o); end
        step();
        clear_inputs();
        step();
    endtask

`ifdef RIB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int unsigned early = 0;
        do_reset();
        m_req_i = 4'b0001;
        s_rdata_i = 32'h5555_AAAA;
        for (int c = 1; c <= 8; c++) begin
            step(); #1;
            if (m_rsp_o !== 4'b0000) early++;
        end
        vectors++; if (early !== 0) begin errors++; $display("FAIL tmo_early got %0d exp 0", early); end
        step(); #1;
        vectors++; if (m_rsp_o !== 4'b0001) begin errors++; $display("FAIL tmo_rsp got %b exp 0001", m_rsp_o); end
        vectors++; if (m_err_o !== 1'b1) begin errors++; $display("FAIL tmo_err got %b exp 1", m_err_o); end
        vectors++; if (m_rdata_o !== 32'h0) begin errors++; $display("FAIL tmo_rdata got %h exp 0", m_rdata_o); end
        step();
        m_req_i = 4'b0000;
        #1;
        vectors++; if (s_req_o !== 1'b0) begin errors++; $display("FAIL tmo_sreq got %b exp 0", s_req_o); end
        m_req_i = 4'b0001;
        for (int c = 1; c <= 8; c++) step();
        step();
        s_ack_i   = 1'b1;
        s_rdata_i = 32'h1234_5678;
        #1;
        vectors++; if (m_rsp_o !== 4'b0001) begin errors++; $display("FAIL tmo_ack_rsp got %b exp 0001", m_rsp_o); end
        vectors++; if (m_err_o !== 1'b0) begin errors++; $display("FAIL tmo_ack_err got %b exp 0", m_err_o); end
        vectors++; if (m_rdata_o !== 32'h1234_5678) begin errors++; $display("FAIL tmo_ack_rdata got %h exp 12345678", m_rdata_o); end
        step();
        clear_inputs();
        step();
    endtask
`else
    task automatic test_no_timeout();
        int unsigned seen_rsp = 0;
        int unsigned seen_err = 0;
        do_reset();
        m_req_i = 4'b0001;
        for (int c = 0; c < 300; c++) begin
            step(); #1;
            if (m_rsp_o !== 4'b0000) seen_rsp++;
            if (m_err_o !== 1'b0) seen_err++;
        end
        vectors++; if (seen_rsp !== 0) begin errors++; $display("FAIL notmo_rsp got %0d exp 0", seen_rsp); end
        vectors++; if (seen_err !== 0) begin errors++; $display("FAIL notmo_err got %0d exp 0", seen_err); end
        vectors++; if (s_req_o !== 1'b1) begin errors++; $display("FAIL notmo_sreq got %b exp 1", s_req_o); end
        s_ack_i = 1'b1;
        #1;
        vectors++; if (m_rsp_o !== 4'b0001) begin errors++; $display("FAIL notmo_rsp_ack got %b exp 0001", m_rsp_o); end
        step();
        clear_inputs();
        step();
    endtask
`endif

    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_drop_req();
        test_reset_busy();
`ifdef RIB_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
